// File: rtl/uart_pkg.sv
// Shared register map, bit positions and helpers for the UART receive controller.
package uart_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_CLEAR  = 4'hC;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  typedef enum logic [1:0] {
    SEL_DATA   = 2'(ADDR_DATA   >> 2),
    SEL_STATUS = 2'(ADDR_STATUS >> 2),
    SEL_CTRL   = 2'(ADDR_CTRL   >> 2),
    SEL_CLEAR  = 2'(ADDR_CLEAR  >> 2)
  } reg_sel_e;

  // Word address bits [3:2] select the register; the byte offset is ignored.
  function automatic reg_sel_e decode_sel(input logic [1:0] word_addr);
    return reg_sel_e'(word_addr);
  endfunction

  function automatic logic [31:0] pack_status(input logic       not_empty,
                                              input logic       full,
                                              input logic       overrun,
                                              input logic       frame_err,
                                              input logic [7:0] count);
    logic [31:0] word;
    word                          = '0;
    word[STAT_NOT_EMPTY]          = not_empty;
    word[STAT_FULL]               = full;
    word[STAT_OVERRUN]            = overrun;
    word[STAT_FRAME_ERR]          = frame_err;
    word[STAT_COUNT_LSB +: 8]     = count;
    return word;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Single-cycle register bus between a host and the UART receive controller.
interface uart_rx_ctrl_if;
  logic        bus_req_in;
  logic        bus_we_in;
  logic [3:0]  bus_addr_in;
  logic [31:0] bus_wdata_in;
  logic [31:0] bus_rdata_out;
  logic        bus_ack_out;

  modport master (
    output bus_req_in, bus_we_in, bus_addr_in, bus_wdata_in,
    input  bus_rdata_out, bus_ack_out
  );

  modport slave (
    input  bus_req_in, bus_we_in, bus_addr_in, bus_wdata_in,
    output bus_rdata_out, bus_ack_out
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; the head is read combinationally so a pop and a
// push to the same slot in one cycle return the old head and store the new byte.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pop is resolved first so a full FIFO can accept a byte in the popping cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; the count alone defines which entries are valid,
  // which keeps the array free of a reset fan-out and mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received bytes in a FIFO and exposes
// DATA/STATUS/CTRL/CLEAR registers over a fixed one-cycle-latency bus.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_byte_in,
  input  logic                rx_done_in,
  input  logic                rx_error_in,
  uart_rx_ctrl_if.slave       bus,
  output logic                irq_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rx_enable_q, rx_enable_d;
  logic             irq_enable_q, irq_enable_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_head;

  reg_sel_e         sel;
  logic             rd_req, wr_req;
  logic             flush, pop_ok, push_ok, rx_accept;
  logic             overrun_set, frame_set, clr_overrun, clr_frame;
  logic             not_empty_d;
  logic             unused_bits;

  assign sel    = decode_sel(bus.bus_addr_in[3:2]);
  assign rd_req = bus.bus_req_in & ~bus.bus_we_in;
  assign wr_req = bus.bus_req_in &  bus.bus_we_in;
  assign unused_bits = ^{bus.bus_addr_in[1:0], bus.bus_wdata_in[31:4]};

  assign flush     = wr_req & (sel == SEL_CTRL) & bus.bus_wdata_in[CTRL_FLUSH];
  assign pop_ok    = rd_req & (sel == SEL_DATA) & ~fifo_empty;
  assign rx_accept = rx_done_in & rx_enable_q & ~rx_error_in;
  assign frame_set = rx_done_in & rx_enable_q &  rx_error_in;

  // Flush swallows the incoming byte silently: no push and no overrun.
  assign push_ok     = rx_accept & ~flush & (~fifo_full | pop_ok);
  assign overrun_set = rx_accept & ~flush &  fifo_full & ~pop_ok;

  assign clr_overrun = wr_req & (sel == SEL_CLEAR) & bus.bus_wdata_in[STAT_OVERRUN];
  assign clr_frame   = wr_req & (sel == SEL_CLEAR) & bus.bus_wdata_in[STAT_FRAME_ERR];
  assign overrun_d   = overrun_set | (overrun_q   & ~clr_overrun);
  assign frame_err_d = frame_set   | (frame_err_q & ~clr_frame);

  assign rx_enable_d  = (wr_req && sel == SEL_CTRL) ? bus.bus_wdata_in[CTRL_RX_EN]  : rx_enable_q;
  assign irq_enable_d = (wr_req && sel == SEL_CTRL) ? bus.bus_wdata_in[CTRL_IRQ_EN] : irq_enable_q;

  // Post-edge emptiness, so irq_out moves in the same cycle STATUS does.
  assign not_empty_d = ~flush & (push_ok | (~fifo_empty & ~(pop_ok && fifo_count == CNT_W'(1))));
  assign irq_d       = irq_enable_d & (not_empty_d | overrun_d | frame_err_d);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      unique case (sel)
        SEL_DATA:   if (!fifo_empty) rdata_d = {24'h0, fifo_head};
        SEL_STATUS: rdata_d = pack_status(~fifo_empty, fifo_full, overrun_q,
                                          frame_err_q, 8'(fifo_count));
        SEL_CTRL: begin
          rdata_d[CTRL_RX_EN]  = rx_enable_q;
          rdata_d[CTRL_IRQ_EN] = irq_enable_q;
        end
        SEL_CLEAR:  rdata_d = '0;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_enable_q  <= 1'b0;
      irq_enable_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      rx_enable_q  <= rx_enable_d;
      irq_enable_q <= irq_enable_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      ack_q        <= bus.bus_req_in;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.bus_ack_out   = ack_q;
  assign bus.bus_rdata_out = rdata_q;
  assign irq_out           = irq_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .flush_i (flush),
    .wdata_i (rx_byte_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized bench for uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_error;
  logic       irq;

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte_in  (rx_byte),
    .rx_done_in  (rx_done),
    .rx_error_in (rx_error),
    .bus         (bus_if.slave),
    .irq_out     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO is a queue, flags are plain bits.
  logic [7:0] mq[$];
  logic       m_ov, m_fe, m_rxen, m_irqen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (mq.size() > 0);
    s[1]     = (mq.size() == DEPTH);
    s[2]     = m_ov;
    s[3]     = m_fe;
    s[15:8]  = 8'(mq.size());
    return s;
  endfunction

  function automatic logic model_irq();
    return m_irqen & ((mq.size() > 0) | m_ov | m_fe);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_fe = 0; m_rxen = 0; m_irqen = 0;
  endtask

  // One bus/receiver cycle: drive, predict, advance one edge, compare.
  task automatic cycle(input logic done, input logic err, input logic [7:0] b,
                       input logic req, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
    logic [31:0] exp_rd;
    logic        old_en, flush, is_rd;
    exp_rd = '0;
    rx_byte  = b;
    rx_done  = done;
    rx_error = err;
    bus_if.bus_req_in   = req;
    bus_if.bus_we_in    = we;
    bus_if.bus_addr_in  = addr;
    bus_if.bus_wdata_in = wdata;

    is_rd = req && !we;
    if (is_rd) begin
      case (addr[3:2])
        2'd0:    if (mq.size() > 0) exp_rd = {24'h0, mq.pop_front()};
        2'd1:    exp_rd = model_status();
        2'd2:    exp_rd = {30'h0, m_irqen, m_rxen};
        default: exp_rd = '0;
      endcase
    end
    flush  = req && we && addr[3:2] == 2'd2 && wdata[2];
    old_en = m_rxen;
    if (req && we && addr[3:2] == 2'd2) begin
      m_rxen  = wdata[0];
      m_irqen = wdata[1];
    end
    if (req && we && addr[3:2] == 2'd3) begin
      if (wdata[2]) m_ov = 0;
      if (wdata[3]) m_fe = 0;
    end
    if (flush) mq.delete();
    if (done && old_en) begin
      if (err) m_fe = 1;
      else if (!flush) begin
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ov = 1;
      end
    end

    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
    bus_if.bus_req_in = 1'b0;
    bus_if.bus_we_in  = 1'b0;

    check("ack", {31'h0, bus_if.bus_ack_out}, {31'h0, req});
    if (is_rd) check("rdata", bus_if.bus_rdata_out, exp_rd);
    check("irq", {31'h0, irq}, {31'h0, model_irq()});
    rdata = bus_if.bus_rdata_out;
  endtask

  task automatic rx(input logic [7:0] b, input logic err);
    logic [31:0] d;
    cycle(1'b1, err, b, 1'b0, 1'b0, 4'h0, 32'h0, d);
  endtask

  task automatic bus_wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] d;
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, addr, data, d);
  endtask

  task automatic bus_rd(input logic [3:0] addr, output logic [31:0] data);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, addr, 32'h0, data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_done = 0; rx_error = 0; rx_byte = 0;
    bus_if.bus_req_in = 0; bus_if.bus_we_in = 0;
    bus_if.bus_addr_in = 0; bus_if.bus_wdata_in = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    model_reset();
    do_reset();
    check("reset_ack",   {31'h0, bus_if.bus_ack_out}, 32'h0);
    check("reset_rdata", bus_if.bus_rdata_out, 32'h0);
    check("reset_irq",   {31'h0, irq}, 32'h0);
    bus_rd(4'h4, d);  check("reset_status", d, 32'h0);

    // Two bytes in, two bytes out.
    bus_wr(4'h8, 32'h1);
    rx(8'h55, 1'b0);  bus_rd(4'h4, d);  check("status_one", d, 32'h0000_0101);
    rx(8'hA3, 1'b0);  bus_rd(4'h6, d);  check("status_two", d, 32'h0000_0201);
    bus_rd(4'h0, d);  check("data_first",  d, 32'h55);
    bus_rd(4'h1, d);  check("data_second", d, 32'hA3);
    bus_rd(4'h4, d);  check("status_drained", d, 32'h0);
    bus_rd(4'h0, d);  check("data_empty", d, 32'h0);

    // Overflow by one byte: seventeenth byte dropped.
    for (int i = 0; i < DEPTH + 1; i++) rx(8'(i + 8'h10), 1'b0);
    bus_rd(4'h4, d);  check("status_overrun", d, 32'h0000_1007);
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(4'h0, d);  check("drain_order", d, 32'(i + 8'h10));
    end
    bus_rd(4'h0, d);  check("byte17_absent", d, 32'h0);
    bus_wr(4'hC, 32'h4);
    bus_rd(4'h4, d);  check("overrun_cleared", d, 32'h0);

    // Pop and push together on a full FIFO.
    for (int i = 0; i < DEPTH; i++) rx(8'(i), 1'b0);
    cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 4'h0, 32'h0, d);
    check("simul_pop_head", d, 32'h0);
    bus_rd(4'h4, d);  check("simul_status", d, 32'h0000_1003);
    for (int i = 0; i < DEPTH; i++) bus_rd(4'h0, d);
    check("simul_last_out", d, 32'hEE);

    // Framing error raises irq; CLEAR drops it.
    bus_wr(4'h8, 32'h3);
    rx(8'h77, 1'b1);
    check("frame_irq", {31'h0, irq}, 32'h1);
    bus_rd(4'h4, d);  check("frame_status", d, 32'h0000_0008);
    bus_wr(4'hC, 32'h8);
    check("frame_irq_clear", {31'h0, irq}, 32'h0);

    // Flush with a coincident byte.
    bus_wr(4'h8, 32'h1);
    for (int i = 0; i < 3; i++) rx(8'(8'h30 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'h99, 1'b1, 1'b1, 4'h8, 32'h5, d);
    bus_rd(4'h4, d);  check("flush_status", d, 32'h0);
    bus_rd(4'h8, d);  check("flush_ctrl", d, 32'h1);

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 4; i++) rx(8'(8'h40 + i), 1'b0);
    rst = 1'b1;
    bus_if.bus_req_in = 1'b1; bus_if.bus_we_in = 1'b0; bus_if.bus_addr_in = 4'h0;
    @(negedge clk);
    bus_if.bus_req_in = 1'b0;
    rst = 1'b0;
    model_reset();
    check("rst_ack",   {31'h0, bus_if.bus_ack_out}, 32'h0);
    check("rst_rdata", bus_if.bus_rdata_out, 32'h0);
    check("rst_irq",   {31'h0, irq}, 32'h0);
    bus_rd(4'h0, d);  check("rst_data_read", d, 32'h0);

    // Randomized traffic in phases that alternately fill and drain.
    bus_wr(4'h8, 32'h3);
    for (int ph = 0; ph < 6; ph++) begin
      for (int n = 0; n < 500; n++) begin
        logic        done, err, req, we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        done  = (ph % 2 == 0) ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
        err   = ($urandom_range(9) == 0);
        req   = ($urandom_range(1) == 0);
        we    = ($urandom_range(3) == 0);
        addr  = 4'($urandom);
        if (ph % 2 == 1 && !we && $urandom_range(1) == 0) addr = 4'h0;
        wdata = $urandom;
        if (we && addr[3:2] == 2'd2) begin
          wdata[0] = ($urandom_range(7) != 0);
          wdata[2] = ($urandom_range(15) == 0);
        end
        cycle(done, err, 8'($urandom), req, we, addr, wdata, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
